bank_cmd_arbiter: RTL

- Consumer end of the bank-machine command stream.
- Takes the cmd_valid/cmd_ready streams of NBANKS bank machines and selects at most one command per cycle, round-robin.
- Enforces inter-bank timing (tCCD, tRRD, tWTR, tRTW) and drives a registered single-phase command to the PHY.
- Sits between the bank machines and the PHY/DFI adapter.

---
 rtl/bank_cmd_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/bank_cmd_arbiter.sv
// Round-robin arbiter between the bank-machine command streams and the PHY.
// Applies inter-bank tCCD/tRRD/tWTR/tRTW spacing and registers one command per cycle.
module bank_cmd_arbiter #(
    parameter int  NBANKS    = 8,
    parameter int  ABITS     = 17,
    parameter int  MAX_BURST = 4,
    localparam int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
    localparam int BCW       = $clog2(MAX_BURST + 1)
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    mux_en,
    input  logic [NBANKS-1:0]       cmd_valid,
    output logic [NBANKS-1:0]       cmd_ready,
    output logic                    cmd_first,
    output logic                    cmd_last,
    input  logic [NBANKS*ABITS-1:0] cmd_payload_a,
    input  logic [NBANKS-1:0]       cmd_payload_cas,
    input  logic [NBANKS-1:0]       cmd_payload_ras,
    input  logic [NBANKS-1:0]       cmd_payload_we,
    input  logic [NBANKS-1:0]       cmd_payload_is_cmd,
    input  logic [NBANKS-1:0]       cmd_payload_is_read,
    input  logic [NBANKS-1:0]       cmd_payload_is_write,
    input  logic [7:0]              cfg_tccd,
    input  logic [7:0]              cfg_trrd,
    input  logic [7:0]              cfg_twtr,
    input  logic [7:0]              cfg_trtw,
    output logic                    phy_cmd_valid,
    output logic                    phy_ras,
    output logic                    phy_cas,
    output logic                    phy_we,
    output logic [ABITS-1:0]        phy_a,
    output logic [BW-1:0]           phy_ba,
    output logic                    phy_rddata_en,
    output logic                    phy_wrdata_en
);

    localparam int T_CCD = 0;
    localparam int T_RRD = 1;
    localparam int T_WTR = 2;
    localparam int T_RTW = 3;

    typedef enum logic {TenureIdle, TenureOwned} tenure_e;

    logic [NBANKS-1:0] isRd, isWr, isAct, eligible;
    logic [ABITS-1:0]  bankAddr [NBANKS];

    logic [3:0][7:0]   timerCfg;
    logic [3:0]        timerOk_q, timerTrig;
    logic [7:0]        timerCnt_q [4];

    tenure_e           tenure_q, tenure_d;
    logic [BW-1:0]     rrPtr_q, rrPtr_d, owner_q, owner_d, sel;
    logic [BCW-1:0]    burst_q, burst_d, burstNext;
    logic              keepOwner, grant, selData, lastCmd;

    // A configured spacing of 0 behaves like 1, i.e. no extra wait.
    function automatic logic [7:0] spacingLoad(input logic [7:0] cfg);
        return (cfg == 8'd0) ? 8'd0 : cfg - 8'd1;
    endfunction

    assign timerCfg = {cfg_trtw, cfg_twtr, cfg_trrd, cfg_tccd};

    always_comb begin
        isRd     = '0;
        isWr     = '0;
        isAct    = '0;
        eligible = '0;
        for (int i = 0; i < NBANKS; i++) begin
            bankAddr[i] = cmd_payload_a[i*ABITS +: ABITS];
            isRd[i]     = cmd_payload_is_read[i];
            isWr[i]     = cmd_payload_is_write[i] & ~cmd_payload_is_read[i];
            isAct[i]    = ~cmd_payload_is_read[i] & ~cmd_payload_is_write[i]
                        & cmd_payload_is_cmd[i] & cmd_payload_ras[i]
                        & ~cmd_payload_cas[i] & ~cmd_payload_we[i];
            if (cmd_valid[i] && mux_en) begin
                if (isRd[i]) begin
                    eligible[i] = timerOk_q[T_CCD] & timerOk_q[T_WTR];
                end else if (isWr[i]) begin
                    eligible[i] = timerOk_q[T_CCD] & timerOk_q[T_RTW];
                end else if (isAct[i]) begin
                    eligible[i] = timerOk_q[T_RRD];
                end else begin
                    eligible[i] = 1'b1;
                end
            end
        end
    end

    // The scan runs backwards so the bank nearest after the pointer wins.
    always_comb begin
        keepOwner = (tenure_q == TenureOwned) & eligible[owner_q] & (burst_q < BCW'(MAX_BURST));
        grant     = keepOwner;
        sel       = owner_q;
        if (!keepOwner) begin
            for (int i = NBANKS; i >= 1; i--) begin
                if (eligible[BW'((int'(rrPtr_q) + i) % NBANKS)]) begin
                    grant = 1'b1;
                    sel   = BW'((int'(rrPtr_q) + i) % NBANKS);
                end
            end
        end
        burstNext = keepOwner ? burst_q + BCW'(1) : BCW'(1);
        selData   = isRd[sel] | isWr[sel];
        lastCmd   = grant & ((burstNext == BCW'(MAX_BURST)) | ~selData);
        cmd_ready = '0;
        cmd_ready[sel] = grant;
        cmd_first = grant & ~keepOwner;
        cmd_last  = lastCmd;
        timerTrig = {grant & isRd[sel], grant & isWr[sel], grant & isAct[sel], grant & selData};
    end

    always_comb begin
        tenure_d = tenure_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        rrPtr_d  = rrPtr_q;
        if ((tenure_q == TenureOwned) && !keepOwner) begin
            tenure_d = TenureIdle;
            rrPtr_d  = owner_q;
        end
        if (grant) begin
            burst_d = burstNext;
            if (lastCmd) begin
                tenure_d = TenureIdle;
                rrPtr_d  = sel;
            end else begin
                tenure_d = TenureOwned;
                owner_d  = sel;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tenure_q <= TenureIdle;
            owner_q  <= '0;
            burst_q  <= '0;
            rrPtr_q  <= '0;
        end else begin
            tenure_q <= tenure_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            rrPtr_q  <= rrPtr_d;
        end
    end

    // Each timer reopens its gate max(cfg,1) cycles after its triggering command.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            timerOk_q <= '1;
            for (int t = 0; t < 4; t++) begin
                timerCnt_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < 4; t++) begin
                if (timerTrig[t]) begin
                    timerCnt_q[t] <= spacingLoad(timerCfg[t]);
                    timerOk_q[t]  <= (spacingLoad(timerCfg[t]) == 8'd0);
                end else if (!timerOk_q[t]) begin
                    timerCnt_q[t] <= timerCnt_q[t] - 8'd1;
                    if (timerCnt_q[t] == 8'd1) begin
                        timerOk_q[t] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !grant) begin
            phy_cmd_valid <= 1'b0;
            phy_ras       <= 1'b0;
            phy_cas       <= 1'b0;
            phy_we        <= 1'b0;
            phy_a         <= '0;
            phy_ba        <= '0;
            phy_rddata_en <= 1'b0;
            phy_wrdata_en <= 1'b0;
        end else begin
            phy_cmd_valid <= 1'b1;
            phy_ras       <= cmd_payload_ras[sel];
            phy_cas       <= cmd_payload_cas[sel];
            phy_we        <= cmd_payload_we[sel];
            phy_a         <= bankAddr[sel];
            phy_ba        <= sel;
            phy_rddata_en <= isRd[sel];
            phy_wrdata_en <= isWr[sel];
        end
    end

endmodule
